// File: rtl/naf_recode.sv
// Recodes an unsigned scalar into non-adjacent form, one signed digit per clock (+1=01, -1=11, 0=00).
// Latency n+1 cycles after start for n digits; start is ignored while busy (no backpressure otherwise).
module naf_recode #(
  parameter int KW = 256,
  parameter int HW = 1024
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [KW-1:0] k,
  input  logic          start,
  output logic [HW-1:0] h,
  output logic [31:0]   hlength,
  output logic          busy,
  output logic          done
);

  localparam int IW = $clog2(HW);
  localparam logic [KW:0] ONE = {{KW{1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [KW:0]   kr_q, kr_d;
  logic [31:0]   cnt_q;
  logic [HW-1:0] h_q;
  logic [31:0]   hlength_q;
  logic          busy_q, done_q;
  logic [1:0]    digit_d;
  logic [IW-1:0] slot_d;

  // kr is one bit wider than k so the +1 on a trailing ...11 pattern never wraps.
  always_comb begin
    digit_d = 2'b00;
    kr_d    = kr_q >> 1;
    if (kr_q[1:0] == 2'b01) begin
      digit_d = 2'b01;
      kr_d    = (kr_q - ONE) >> 1;
    end else if (kr_q[1:0] == 2'b11) begin
      digit_d = 2'b11;
      kr_d    = (kr_q + ONE) >> 1;
    end
  end

  assign slot_d = {cnt_q[IW-2:0], 1'b0};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      kr_q      <= '0;
      cnt_q     <= '0;
      h_q       <= '0;
      hlength_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            kr_q    <= {1'b0, k};
            h_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (kr_q == '0) begin
            hlength_q <= cnt_q;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end else begin
            h_q[slot_d +: 2] <= digit_d;
            kr_q             <= kr_d;
            cnt_q            <= cnt_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign h       = h_q;
  assign hlength = hlength_q;
  assign busy    = busy_q;
  assign done    = done_q;

  a_busy_done_excl: assert property (@(posedge clk) !(busy_q && done_q));

endmodule
